// File: rtl/common.sv
// Shared types and constants for the memory stage: access sizes, FSM states and
// byte-strobe base patterns.
package common;

   typedef enum logic [1:0] {
      MSIZE1 = 2'd0,
      MSIZE2 = 2'd1,
      MSIZE4 = 2'd2,
      MSIZE8 = 2'd3
   } msize_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ  = 3'd1,
      WAIT = 3'd2,
      DONE = 3'd3,
      DROP = 3'd4
   } mem_state_t;

   localparam logic [7:0] STRB_B = 8'h01;
   localparam logic [7:0] STRB_H = 8'h03;
   localparam logic [7:0] STRB_W = 8'h0F;
   localparam logic [7:0] STRB_D = 8'hFF;

   function automatic logic [7:0] size_strobe(msize_t size);
      logic [7:0] strb;
      unique case (size)
         MSIZE1:  strb = STRB_B;
         MSIZE2:  strb = STRB_H;
         MSIZE4:  strb = STRB_W;
         default: strb = STRB_D;
      endcase
      return strb;
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_mask(msize_t size);
      logic [2:0] mask;
      unique case (size)
         MSIZE1:  mask = 3'b000;
         MSIZE2:  mask = 3'b001;
         MSIZE4:  mask = 3'b011;
         default: mask = 3'b111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load-data alignment: shifts the response word down to the byte
// offset, truncates to the access size and sign- or zero-extends.
module load_extract
   import common::*;
(
   input  logic [63:0] dresp_data,
   input  logic [2:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [63:0] result
);

   logic [63:0] shifted;

   always_comb begin
      shifted = dresp_data >> {addr_lo, 3'b000};
      result  = shifted;
      unique case (msize_t'(size))
         MSIZE1: result = is_unsigned ? {56'b0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
         MSIZE2: result = is_unsigned ? {48'b0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
         MSIZE4: result = is_unsigned ? {32'b0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
         MSIZE8: result = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one bus request per load/store, stalls the pipe
// until the response returns. Optional MISALIGN_CHECK_EN traps misaligned accesses.
module mem_stage
   import common::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [63:0] ALU_result_in,
   input  logic [63:0] reg_Q2_in,
   input  logic        advance,
   input  logic        flush,
   output logic        dreq_valid,
   output logic [63:0] dreq_addr,
   output logic        dreq_write,
   output logic [7:0]  dreq_strobe,
   output logic [63:0] dreq_data,
   input  logic        dreq_ready,
   input  logic        dresp_valid,
   input  logic [63:0] dresp_data,
   output logic [63:0] Memory_Data_out,
   output logic        mem_busy,
   output logic        misalign_out
);

   mem_state_t  state_q, state_d;
   logic [63:0] addr_q, data_q, mdata_q, mdata_d, load_val;
   logic [7:0]  strobe_q;
   logic [1:0]  size_q;
   logic        write_q, uns_q, pend_q, pend_d;
   logic        start, capture, misaligned;
   msize_t      req_size;

   assign req_size = msize_t'(mem_size);
   // Gated by reset so the stall request is low while reset is held.
   assign start    = reset & in_valid & (mem_read | mem_write) & ~flush;

`ifdef MISALIGN_CHECK_EN
   logic misalign_q;
   assign misaligned   = (ALU_result_in[2:0] & size_mask(req_size)) != 3'b000;
   assign misalign_out = (state_q == DONE) & misalign_q;
`else
   assign misaligned   = 1'b0;
   assign misalign_out = 1'b0;
`endif

   load_extract u_load_extract (
      .dresp_data  (dresp_data),
      .addr_lo     (addr_q[2:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .result      (load_val)
   );

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      mdata_d    = mdata_q;
      capture    = 1'b0;
      mem_busy   = 1'b0;
      dreq_valid = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               capture  = 1'b1;
               mem_busy = 1'b1;
               mdata_d  = '0;
               pend_d   = 1'b0;
               state_d  = misaligned ? DONE : REQ;
            end
         end
         REQ: begin
            mem_busy   = 1'b1;
            dreq_valid = 1'b1;
            if (flush) begin
               // The request still has to reach the bus if not yet accepted.
               state_d = DROP;
               pend_d  = ~dreq_ready;
            end else if (dreq_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            mem_busy = 1'b1;
            if (dresp_valid) begin
               state_d = flush ? IDLE : DONE;
               mdata_d = write_q ? '0 : load_val;
            end else if (flush) begin
               state_d = DROP;
            end
         end
         DROP: begin
            mem_busy   = 1'b1;
            dreq_valid = pend_q;
            if (pend_q) begin
               if (dreq_ready) pend_d = 1'b0;
            end else if (dresp_valid) begin
               state_d = IDLE;
            end
         end
         DONE: begin
            if (advance | flush) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         data_q   <= '0;
         strobe_q <= '0;
         write_q  <= 1'b0;
         size_q   <= '0;
         uns_q    <= 1'b0;
         pend_q   <= 1'b0;
         mdata_q  <= '0;
`ifdef MISALIGN_CHECK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         mdata_q <= mdata_d;
         if (capture) begin
            addr_q   <= ALU_result_in;
            write_q  <= mem_write;
            size_q   <= mem_size;
            uns_q    <= mem_unsigned;
            strobe_q <= size_strobe(req_size) << ALU_result_in[2:0];
            data_q   <= reg_Q2_in << {ALU_result_in[2:0], 3'b000};
`ifdef MISALIGN_CHECK_EN
            misalign_q <= misaligned;
`endif
         end
      end
   end

   assign dreq_addr       = addr_q;
   assign dreq_write      = write_q;
   assign dreq_strobe     = strobe_q;
   assign dreq_data       = data_q;
   assign Memory_Data_out = (state_q == DONE) ? mdata_q : '0;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios, then random loads/stores checked by a
// byte-level memory reference model through request and result scoreboards.
module tb_mem_stage;

   logic        clk = 1'b0, reset = 1'b0;
   logic        in_valid = 0, mem_read = 0, mem_write = 0, mem_unsigned = 0;
   logic [1:0]  mem_size = 0;
   logic [63:0] ALU_result_in = 0, reg_Q2_in = 0;
   logic        advance = 0, flush = 0;
   logic        dreq_valid, dreq_write, dreq_ready, dresp_valid;
   logic [63:0] dreq_addr, dreq_data, dresp_data, Memory_Data_out;
   logic [7:0]  dreq_strobe;
   logic        mem_busy, misalign_out;

   // Directed drive vs. automatic responder drive of the bus inputs.
   logic        auto_en = 0, sb_en = 0, op_live = 0;
   logic        d_ready = 0, d_resp_valid = 0, a_ready = 0, a_resp_valid = 0;
   logic [63:0] d_resp_data = 0, a_resp_data = 0;
   assign dreq_ready  = auto_en ? a_ready : d_ready;
   assign dresp_valid = auto_en ? a_resp_valid : d_resp_valid;
   assign dresp_data  = auto_en ? a_resp_data : d_resp_data;

`ifdef MISALIGN_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif
   localparam logic [63:0] BASE = 64'h8000_0000;

   mem_stage dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read),
      .mem_write(mem_write), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
      .ALU_result_in(ALU_result_in), .reg_Q2_in(reg_Q2_in), .advance(advance),
      .flush(flush), .dreq_valid(dreq_valid), .dreq_addr(dreq_addr),
      .dreq_write(dreq_write), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
      .dreq_ready(dreq_ready), .dresp_valid(dresp_valid), .dresp_data(dresp_data),
      .Memory_Data_out(Memory_Data_out), .mem_busy(mem_busy), .misalign_out(misalign_out)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] ref_mem [8];
   logic [63:0] bus_mem [8];

   typedef struct { logic [63:0] addr; logic [63:0] data; logic [7:0] strb; logic wr; } req_t;
   typedef struct { logic [63:0] data; logic mis; } res_t;
   req_t req_q[$];
   res_t res_q[$];

   function automatic int nbytes(input logic [1:0] s);
      return 1 << s;
   endfunction

   function automatic int widx(input logic [63:0] a);
      return int'(a[5:3]);
   endfunction

   function automatic logic [63:0] ref_load(input logic [63:0] word, input int o,
                                            input logic [1:0] s, input logic uns);
      logic [63:0] v = '0;
      int n = nbytes(s);
      for (int k = 0; k < n; k++)
         if (o + k < 8) v[8*k +: 8] = word[8*(o+k) +: 8];
      if (!uns && n < 8 && v[8*n-1])
         for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] ref_strb(input int o, input logic [1:0] s);
      logic [7:0] m = '0;
      for (int k = 0; k < nbytes(s); k++)
         if (o + k < 8) m[o+k] = 1'b1;
      return m;
   endfunction

   function automatic logic [63:0] ref_sdata(input int o, input logic [63:0] q2);
      logic [63:0] d = '0;
      for (int j = o; j < 8; j++) d[8*j +: 8] = q2[8*(j-o) +: 8];
      return d;
   endfunction

   // ---------------- automatic bus responder ----------------
   int rsp_cnt = 0, p_idx = 0;
   logic p_wr = 0;
   initial begin
      forever begin
         @(negedge clk);
         if (auto_en) begin
            a_resp_valid = 1'b0;
            if (rsp_cnt > 0) begin
               rsp_cnt--;
               if (rsp_cnt == 0) begin
                  a_resp_valid = 1'b1;
                  a_resp_data  = p_wr ? {$urandom, $urandom} : bus_mem[p_idx];
               end
            end
            a_ready = ($urandom_range(0, 3) != 0);
            if (a_ready && dreq_valid) begin
               p_wr  = dreq_write;
               p_idx = widx(dreq_addr);
               if (dreq_write)
                  for (int b = 0; b < 8; b++)
                     if (dreq_strobe[b]) bus_mem[p_idx][8*b +: 8] = dreq_data[8*b +: 8];
               rsp_cnt = $urandom_range(1, 3);
            end
         end
      end
   end

   // ---------------- monitors ----------------
   initial begin
      req_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_en && dreq_valid && dreq_ready) begin
            if (req_q.size() == 0) begin
               total++; bad++;
               $display("FAIL req_unexpected: got request addr %0h expected none", dreq_addr);
            end else begin
               e = req_q.pop_front();
               chk("req_addr", dreq_addr, e.addr);
               chk("req_write", {63'b0, dreq_write}, {63'b0, e.wr});
               chk("req_strobe", {56'b0, dreq_strobe}, {56'b0, e.strb});
               chk("req_data", dreq_data, e.data);
            end
         end
      end
   end

   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         #2;
         if (sb_en && op_live && in_valid && !mem_busy) begin
            if (res_q.size() == 0) begin
               total++; bad++;
               $display("FAIL res_unexpected: got result %0h expected none", Memory_Data_out);
            end else begin
               r = res_q.pop_front();
               chk("res_data", Memory_Data_out, r.data);
               chk("res_misalign", {63'b0, misalign_out}, {63'b0, r.mis});
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_op(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [63:0] a, input logic [63:0] q2);
      mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
      ALU_result_in = a; reg_Q2_in = q2; in_valid = 1'b1;
   endtask

   task automatic clr_op();
      in_valid = 0; mem_read = 0; mem_write = 0;
   endtask

   // Fixed-latency directed access: ready immediately, response one cycle later.
   task automatic run_direct(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [63:0] a, input logic [63:0] q2,
                             input logic [63:0] rdata, output logic [63:0] res,
                             output int busy);
      busy = 0;
      @(negedge clk); set_op(rd, wr, sz, uns, a, q2); d_ready = 1;
      #2 if (mem_busy) busy++;
      @(negedge clk); clr_op();
      #2 if (mem_busy) busy++;
      @(negedge clk); d_ready = 0; d_resp_valid = 1; d_resp_data = rdata;
      #2 if (mem_busy) busy++;
      @(negedge clk); d_resp_valid = 0;
      #2 if (mem_busy) busy++;
      res = Memory_Data_out; advance = 1;
      @(negedge clk); advance = 0;
   endtask

   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [63:0] a, input logic [63:0] q2);
      int   o = int'(a[2:0]);
      int   wi = widx(a);
      bit   mis = (a % nbytes(sz)) != 0;
      res_t r;
      req_t e;
      logic done = 0;
      r.data = '0; r.mis = 1'b0;
      if (rd | wr) begin
         if (CHK && mis) begin
            r.mis = 1'b1;
         end else begin
            e.addr = a; e.wr = wr; e.strb = ref_strb(o, sz); e.data = ref_sdata(o, q2);
            req_q.push_back(e);
            if (wr) begin
               for (int k = 0; k < nbytes(sz); k++)
                  if (o + k < 8) ref_mem[wi][8*(o+k) +: 8] = q2[8*k +: 8];
            end else begin
               r.data = ref_load(ref_mem[wi], o, sz, uns);
            end
         end
      end
      res_q.push_back(r);
      @(negedge clk);
      set_op(rd, wr, sz, uns, a, q2);
      op_live = 1;
      for (int c = 0; c < 60; c++) begin
         #3;
         if (!mem_busy) begin
            done = 1; advance = 1;
            break;
         end
         @(negedge clk);
      end
      chk("op_complete", {63'b0, done}, 64'd1);
      @(negedge clk);
      advance = 0; op_live = 0; clr_op();
   endtask

   // ---------------- main sequence ----------------
   initial begin
      logic [63:0] res;
      int busy;
      logic [1:0] sz;
      logic [63:0] a;
      int kind;

      in_valid = 1; mem_read = 1;
      #3;
      chk("rst_busy", {63'b0, mem_busy}, 64'd0);
      chk("rst_dreq_valid", {63'b0, dreq_valid}, 64'd0);
      chk("rst_dreq_addr", dreq_addr, 64'd0);
      chk("rst_dreq_strobe", {56'b0, dreq_strobe}, 64'd0);
      chk("rst_dreq_data", dreq_data, 64'd0);
      chk("rst_mdo", Memory_Data_out, 64'd0);
      chk("rst_misalign", {63'b0, misalign_out}, 64'd0);
      clr_op();
      #9 reset = 1;

      // LD D, immediate ready, response next cycle
      run_direct(1, 0, 2'd3, 0, 64'h8000_0008, 0, 64'h1122_3344_5566_7788, res, busy);
      chk("ld_d_data", res, 64'h1122_3344_5566_7788);
      chk("ld_d_busy_cycles", 64'(busy), 64'd3);
      #2 chk("idle_mdo_zero", Memory_Data_out, 64'd0);

      // Byte loads: sign/zero extension
      run_direct(1, 0, 2'd0, 0, 64'h8000_0003, 0, 64'h0000_0000_00FF_0000, res, busy);
      chk("lb_zero", res, 64'd0);
      run_direct(1, 0, 2'd0, 0, 64'h8000_0002, 0, 64'h0000_0000_00FF_0000, res, busy);
      chk("lb_neg", res, 64'hFFFF_FFFF_FFFF_FFFF);
      run_direct(1, 0, 2'd0, 1, 64'h8000_0002, 0, 64'h0000_0000_00FF_0000, res, busy);
      chk("lbu", res, 64'hFF);

      // SH at offset 6 with ready held low
      @(negedge clk); set_op(0, 1, 2'd1, 0, 64'h8000_0006, 64'hABCD); d_ready = 0;
      @(negedge clk); clr_op();
      for (int i = 0; i < 4; i++) begin
         #2;
         chk("sh_valid", {63'b0, dreq_valid}, 64'd1);
         chk("sh_strobe", {56'b0, dreq_strobe}, 64'hC0);
         chk("sh_data", dreq_data, 64'hABCD_0000_0000_0000);
         chk("sh_addr", dreq_addr, 64'h8000_0006);
         @(negedge clk);
      end
      d_ready = 1;
      @(negedge clk); d_ready = 0; d_resp_valid = 1; d_resp_data = 64'h1234;
      @(negedge clk); d_resp_valid = 0;
      #2 chk("sh_done_busy", {63'b0, mem_busy}, 64'd0);
      chk("sh_done_mdo", Memory_Data_out, 64'd0);
      advance = 1;
      @(negedge clk); advance = 0;

      // LW flushed while waiting for the response
      @(negedge clk); set_op(1, 0, 2'd2, 0, 64'h8000_0010, 0); d_ready = 1;
      @(negedge clk); clr_op();
      @(negedge clk); d_ready = 0; flush = 1;
      #2 chk("flush_wait_busy", {63'b0, mem_busy}, 64'd1);
      @(negedge clk); flush = 0;
      #2 chk("drop_busy", {63'b0, mem_busy}, 64'd1);
      chk("drop_no_req", {63'b0, dreq_valid}, 64'd0);
      chk("drop_mdo", Memory_Data_out, 64'd0);
      @(negedge clk); d_resp_valid = 1; d_resp_data = 64'h0000_0000_7777_7777;
      #2 chk("drop_busy2", {63'b0, mem_busy}, 64'd1);
      @(negedge clk); d_resp_valid = 0;
      #2 chk("drop_exit_busy", {63'b0, mem_busy}, 64'd0);
      chk("drop_exit_mdo", Memory_Data_out, 64'd0);
      @(negedge clk);
      #2 chk("drop_no_done", Memory_Data_out, 64'd0);

      // Misaligned LW
      @(negedge clk); set_op(1, 0, 2'd2, 0, 64'h8000_0002, 0); d_ready = 0;
      @(negedge clk); clr_op();
      #2;
`ifdef MISALIGN_CHECK_EN
      chk("mis_no_req", {63'b0, dreq_valid}, 64'd0);
      chk("mis_flag", {63'b0, misalign_out}, 64'd1);
      chk("mis_mdo", Memory_Data_out, 64'd0);
      advance = 1;
      @(negedge clk); advance = 0;
`else
      chk("mis_req", {63'b0, dreq_valid}, 64'd1);
      chk("mis_strobe", {56'b0, dreq_strobe}, 64'h3C);
      chk("mis_flag_off", {63'b0, misalign_out}, 64'd0);
      d_ready = 1;
      @(negedge clk); d_ready = 0; d_resp_valid = 1; d_resp_data = 64'h0;
      @(negedge clk); d_resp_valid = 0; advance = 1;
      @(negedge clk); advance = 0;
`endif

      // Reset pulse during REQ
      @(negedge clk); set_op(1, 0, 2'd3, 0, 64'h8000_0018, 0); d_ready = 0;
      @(negedge clk); clr_op();
      #2 chk("pre_rst_req", {63'b0, dreq_valid}, 64'd1);
      reset = 0;
      #1;
      chk("rst_mid_valid", {63'b0, dreq_valid}, 64'd0);
      chk("rst_mid_addr", dreq_addr, 64'd0);
      chk("rst_mid_busy", {63'b0, mem_busy}, 64'd0);
      @(negedge clk); reset = 1;
      @(negedge clk); d_resp_valid = 1; d_resp_data = 64'hDEAD_BEEF_0000_0001;
      #2 chk("stale_resp_busy", {63'b0, mem_busy}, 64'd0);
      @(negedge clk); d_resp_valid = 0;
      #2 chk("stale_resp_mdo", Memory_Data_out, 64'd0);
      run_direct(1, 0, 2'd3, 0, 64'h8000_0020, 0, 64'h0102_0304_0506_0708, res, busy);
      chk("post_rst_ld", res, 64'h0102_0304_0506_0708);
      chk("post_rst_busy", 64'(busy), 64'd3);

      // Random traffic against the reference model
      for (int i = 0; i < 8; i++) begin
         ref_mem[i] = {$urandom, $urandom};
         bus_mem[i] = ref_mem[i];
      end
      @(negedge clk); auto_en = 1; sb_en = 1;
      for (int n = 0; n < 200; n++) begin
         sz = 2'($urandom_range(0, 3));
         a = BASE + 64'($urandom_range(0, 63));
         if ($urandom_range(0, 9) < 7) a = a & ~64'(nbytes(sz) - 1);
         kind = $urandom_range(0, 9);
         if (kind < 5)      issue(1, 0, sz, 1'($urandom), a, 0);
         else if (kind < 9) issue(0, 1, sz, 0, a, {$urandom, $urandom});
         else               issue(0, 0, sz, 0, a, 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (8) @(negedge clk);
      chk("req_q_drained", 64'(req_q.size()), 64'd0);
      chk("res_q_drained", 64'(res_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
